// File: rtl/game_tick_scheduler_if.sv
// Game-state controls, period configuration and issued ticks
// for the game tick scheduler.
interface game_tick_scheduler_if;
    logic       Start;
    logic       Stop;
    logic       Pause;
    logic       Level_up;
    logic       Cfg_we;
    logic [1:0] Cfg_ch;
    logic [9:0] Cfg_period;
    logic [3:0] Tick;
    logic       Running;
    logic       Overrun;

    modport master (
        output Start, Stop, Pause, Level_up,
        output Cfg_we, Cfg_ch, Cfg_period,
        input  Tick, Running, Overrun
    );

    modport slave (
        input  Start, Stop, Pause, Level_up,
        input  Cfg_we, Cfg_ch, Cfg_period,
        output Tick, Running, Overrun
    );
endinterface

// File: rtl/game_tick_scheduler.sv
// Base-tick prescaler, four channel down-counters and a fixed-priority
// tick issuer. Optional overrun detection: TICK_SCHED_OVERRUN_EN.
module game_tick_scheduler #(
    parameter int         BASE_DIV   = 100000,
    parameter int         LVL_STEP   = 50,
    parameter int         MIN_PERIOD = 20,
    parameter logic [9:0] P0_INIT    = 10'd500,
    parameter logic [9:0] P1_INIT    = 10'd10,
    parameter logic [9:0] P2_INIT    = 10'd30,
    parameter logic [9:0] P3_INIT    = 10'd0
) (
    input logic                  CLK,
    input logic                  Rst,
    game_tick_scheduler_if.slave bus
);
    typedef enum logic [1:0] {STOPPED, RUNNING, PAUSED} state_t;

    localparam int PW = $clog2(BASE_DIV);
    localparam logic [3:0][9:0] INIT = {P3_INIT, P2_INIT, P1_INIT, P0_INIT};

    state_t          state, state_nxt;
    logic [PW-1:0]   presc;
    logic [9:0]      period     [4];
    logic [9:0]      period_nxt [4];
    logic [9:0]      cnt        [4];
    logic [9:0]      lvl_val;
    logic [3:0]      pending;
    logic [3:0]      set_mask;
    logic [3:0]      grant;
    logic [3:0]      clr_mask;
    logic [3:0]      tick_q;
    logic            base_tick;
    logic            issue;
    logic            clear_all;

    // Game-state register
    always_ff @(posedge CLK) begin
        if (Rst) state <= STOPPED;
        else     state <= state_nxt;
    end

    // Next state: Stop overrides everything, Start only leaves STOPPED
    always_comb begin
        state_nxt = state;
        unique case (state)
            STOPPED: if (bus.Start)  state_nxt = RUNNING;
            RUNNING: if (bus.Pause)  state_nxt = PAUSED;
            PAUSED:  if (!bus.Pause) state_nxt = RUNNING;
            default: state_nxt = STOPPED;
        endcase
        if (bus.Stop) state_nxt = STOPPED;
    end

    assign base_tick = (state == RUNNING) && (presc == PW'(BASE_DIV - 1));
    assign clear_all = bus.Stop || (state == STOPPED);
    // Only issue if the game is still running after this edge
    assign issue     = (state == RUNNING) && (state_nxt == RUNNING)
                       && (pending != 4'd0);
    assign grant     = pending & (~pending + 4'd1);
    assign clr_mask  = issue ? grant : 4'd0;

    // Level-up result in 11 bits so the subtraction cannot wrap
    always_comb begin
        lvl_val = period[0];
        if (period[0] == 10'd0)
            lvl_val = 10'd0;
        else if ({1'b0, period[0]} >= 11'(LVL_STEP + MIN_PERIOD))
            lvl_val = 10'({1'b0, period[0]} - 11'(LVL_STEP));
        else
            lvl_val = 10'(MIN_PERIOD);
    end

    // Period updates: level-up first, a config write to ch0 overrides it
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            period_nxt[i] = period[i];
        end
        if (bus.Level_up) period_nxt[0] = lvl_val;
        for (int i = 0; i < 4; i++) begin
            if (bus.Cfg_we && bus.Cfg_ch == 2'(i))
                period_nxt[i] = bus.Cfg_period;
        end
    end

    // Channel expiry on base tick; counter at 0 is treated as expired
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            set_mask[i] = base_tick && (period[i] != 10'd0)
                          && (cnt[i] <= 10'd1);
        end
    end

    // Period registers
    always_ff @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (Rst) period[i] <= INIT[i];
            else     period[i] <= period_nxt[i];
        end
    end

    // Channel down-counters, held at their period while stopped
    always_ff @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (Rst)
                cnt[i] <= INIT[i];
            else if (clear_all)
                cnt[i] <= period_nxt[i];
            else if (base_tick && period[i] != 10'd0)
                cnt[i] <= (cnt[i] <= 10'd1) ? period[i] : cnt[i] - 10'd1;
        end
    end

    // Prescaler advances only while running
    always_ff @(posedge CLK) begin
        if (Rst || clear_all)
            presc <= '0;
        else if (state == RUNNING)
            presc <= base_tick ? '0 : presc + PW'(1);
    end

    // Pending queue: a new expiry beats a same-edge issue clear
    always_ff @(posedge CLK) begin
        if (Rst || clear_all) pending <= 4'd0;
        else                  pending <= (pending & ~clr_mask) | set_mask;
    end

    // One-cycle registered tick pulse
    always_ff @(posedge CLK) begin
        if (Rst) tick_q <= 4'd0;
        else     tick_q <= clr_mask;
    end

    assign bus.Tick    = tick_q;
    assign bus.Running = (state == RUNNING);

`ifdef TICK_SCHED_OVERRUN_EN
    logic ovr_q;

    // Sticky flag for an expiry that lands on an undrained pending bit
    always_ff @(posedge CLK) begin
        if (Rst || bus.Stop)
            ovr_q <= 1'b0;
        else if ((set_mask & pending & ~clr_mask) != 4'd0)
            ovr_q <= 1'b1;
    end

    assign bus.Overrun = ovr_q;
`else
    assign bus.Overrun = 1'b0;
`endif
endmodule
